// File: rtl/uart_alu_sequencer.sv
// -----------------------------------------------------------------------------
// uart_alu_sequencer
//
// Frame-level controller between the UART RX/TX FIFOs and a shared ALU.
// It parses 5-byte command frames (SOF, OP, A, B, CHK) from the RX FIFO and
// checks the XOR checksum. Operands are committed to the ALU only for good
// frames. The ALU result is sampled and a status/result response is queued
// into the TX FIFO. Frames that stall between bytes are aborted by a timeout,
// and checksum/timeout errors are counted.
//
// Ports:
//   clock         system clock, rising edge
//   i_reset_n     asynchronous active-low reset
//   i_rx_empty    RX FIFO empty flag
//   i_rx_data     RX FIFO head word (first-word-fall-through)
//   o_rx_rd       RX FIFO pop strobe (combinational)
//   i_tx_full     TX FIFO full flag
//   o_tx_wr       TX FIFO push strobe (combinational)
//   o_tx_data     TX FIFO write word
//   o_operation   registered ALU op code (low NB_OP bits of OP)
//   o_a_data      registered ALU operand A
//   o_b_data      registered ALU operand B
//   i_alu_result  combinational ALU result
//   o_busy        high in every state except IDLE
//   o_err_cnt     saturating count of checksum and timeout errors
// -----------------------------------------------------------------------------
module uart_alu_sequencer #(
    parameter int              DBIT        = 8,
    parameter int              NB_OP       = 6,
    parameter logic [DBIT-1:0] SOF         = 8'hA5,
    parameter int              TIMEOUT_CYC = 1_000_000,
    parameter int              NB_TO       = 20
) (
    input  logic             clock,
    input  logic             i_reset_n,
    input  logic             i_rx_empty,
    input  logic [DBIT-1:0]  i_rx_data,
    output logic             o_rx_rd,
    input  logic             i_tx_full,
    output logic             o_tx_wr,
    output logic [DBIT-1:0]  o_tx_data,
    output logic [NB_OP-1:0] o_operation,
    output logic [DBIT-1:0]  o_a_data,
    output logic [DBIT-1:0]  o_b_data,
    input  logic [DBIT-1:0]  i_alu_result,
    output logic             o_busy,
    output logic [7:0]       o_err_cnt
);

    typedef enum logic [3:0] {
        IDLE,
        GET_OP,
        GET_A,
        GET_B,
        GET_CHK,
        COMMIT,
        SAMPLE,
        SEND_STAT,
        SEND_RES
    } state_e;

    localparam logic [DBIT-1:0]  ST_OK      = '0;
    localparam logic [DBIT-1:0]  ST_BAD_CHK = DBIT'(8'hE1);
    localparam logic [DBIT-1:0]  ST_TIMEOUT = DBIT'(8'hE2);
    localparam logic [NB_TO-1:0] TO_LAST    = NB_TO'(TIMEOUT_CYC - 1);

    state_e            state_q,     state_d;
    logic [DBIT-1:0]   op_sh_q,     op_sh_d;
    logic [DBIT-1:0]   a_sh_q,      a_sh_d;
    logic [DBIT-1:0]   b_sh_q,      b_sh_d;
    logic [NB_OP-1:0]  operation_q, operation_d;
    logic [DBIT-1:0]   a_q,         a_d;
    logic [DBIT-1:0]   b_q,         b_d;
    logic [DBIT-1:0]   result_q,    result_d;
    logic [DBIT-1:0]   status_q,    status_d;
    logic [NB_TO-1:0]  to_cnt_q,    to_cnt_d;
    logic [7:0]        err_cnt_q,   err_cnt_d;

    logic              rx_rd;
    logic              tx_wr;
    logic [DBIT-1:0]   tx_data;
    logic              err_inc;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets its default before the case statement so no
    // path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        op_sh_d     = op_sh_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        operation_d = operation_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        status_d    = status_q;
        to_cnt_d    = to_cnt_q;
        err_cnt_d   = err_cnt_q;
        rx_rd       = 1'b0;
        tx_wr       = 1'b0;
        tx_data     = '0;
        err_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                // Drain everything; only SOF opens a frame.
                if (!i_rx_empty) begin
                    rx_rd = 1'b1;
                    if (i_rx_data == SOF) begin
                        state_d  = GET_OP;
                        to_cnt_d = '0;
                    end
                end
            end

            GET_OP, GET_A, GET_B, GET_CHK: begin
                if (!i_rx_empty) begin
                    rx_rd    = 1'b1;
                    to_cnt_d = '0;
                    case (state_q)
                        GET_OP: begin
                            op_sh_d = i_rx_data;
                            state_d = GET_A;
                        end
                        GET_A: begin
                            a_sh_d  = i_rx_data;
                            state_d = GET_B;
                        end
                        GET_B: begin
                            b_sh_d  = i_rx_data;
                            state_d = GET_CHK;
                        end
                        default: begin
                            if (i_rx_data == (op_sh_q ^ a_sh_q ^ b_sh_q)) begin
                                state_d = COMMIT;
                            end else begin
                                status_d = ST_BAD_CHK;
                                err_inc  = 1'b1;
                                state_d  = SEND_STAT;
                            end
                        end
                    endcase
                end else if (to_cnt_q == TO_LAST) begin
                    // Last allowed idle cycle expired with no byte: abort.
                    status_d = ST_TIMEOUT;
                    err_inc  = 1'b1;
                    state_d  = SEND_STAT;
                end else begin
                    to_cnt_d = to_cnt_q + NB_TO'(1);
                end
            end

            COMMIT: begin
                operation_d = op_sh_q[NB_OP-1:0];
                a_d         = a_sh_q;
                b_d         = b_sh_q;
                status_d    = ST_OK;
                state_d     = SAMPLE;
            end

            SAMPLE: begin
                // ALU inputs were registered one edge ago; result is settled.
                result_d = i_alu_result;
                state_d  = SEND_STAT;
            end

            SEND_STAT: begin
                tx_data = status_q;
                if (!i_tx_full) begin
                    tx_wr   = 1'b1;
                    state_d = (status_q == ST_OK) ? SEND_RES : IDLE;
                end
            end

            SEND_RES: begin
                tx_data = result_q;
                if (!i_tx_full) begin
                    tx_wr   = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        if (err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order. All of these
    // are plain flops (no RAM), so each one is cleared by the async reset.
    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            op_sh_q     <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            operation_q <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            status_q    <= '0;
            to_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_sh_q     <= op_sh_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            operation_q <= operation_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            status_q    <= status_d;
            to_cnt_q    <= to_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_rx_rd     = rx_rd;
    assign o_tx_wr     = tx_wr;
    assign o_tx_data   = tx_data;
    assign o_operation = operation_q;
    assign o_a_data    = a_q;
    assign o_b_data    = b_q;
    assign o_busy      = (state_q != IDLE);
    assign o_err_cnt   = err_cnt_q;

endmodule
